data_memory_pipe: RTL and testbench

Parametrised successor to the single-cycle data memory. It is a word-organised, byte-addressed data RAM with a valid/ready request channel, a configurable read latency, per-byte write strobes, and a buffered, back-pressurable response channel. It reports misaligned and out-of-range accesses. It sits between the pipelined core's MEM stage and its writeback path.

---
 rtl/data_memory_pipe_pkg.sv | 41 ++++
 rtl/data_memory_pipe_if.sv | 30 +++
 rtl/data_memory_pipe_rsp_fifo.sv | 64 ++++++
 rtl/data_memory_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_data_memory_pipe.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_pipe_pkg.sv
// Shared types, constants and parameter-legality helpers for the pipelined
// data memory (data_memory_pipe) and its response FIFO.
`ifndef DMEM_PKG_SV
`define DMEM_PKG_SV

// Elaboration-time legality check, expanded inside a module body as a
// generate-if so that an illegal parameter set stops elaboration.
`define DMEM_PARAM_CHECK(label, cond, msg) \
    if (!(cond)) begin : label \
        $error(msg); \
    end

package dmem_pkg;

    // Low address bits that select a byte inside a 32-bit word.
    localparam int BYTE_OFF_W = 2;

    // Data width of the default response entry.
    localparam int RSP_DATA_W = 32;

    // Read response: data word plus error flag.
    typedef struct packed {
        logic [RSP_DATA_W-1:0] data;
        logic                  err;
    } rsp_t;

    function automatic bit rd_lat_ok(input int rd_lat);
        return (rd_lat >= 1) && (rd_lat <= 4);
    endfunction

    function automatic bit rsp_depth_ok(input int rsp_depth, input int rd_lat);
        return rsp_depth >= rd_lat;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

`endif

// File: rtl/data_memory_pipe_if.sv
// Request/response bus of the pipelined data memory. The core side uses the
// master modport, the memory uses the slave modport.
interface data_memory_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  err_sticky;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_sticky
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, err_sticky
    );

endinterface

// File: rtl/data_memory_pipe_rsp_fifo.sv
// dmem_rsp_fifo: synchronous FIFO holding read responses. The head entry is
// presented combinationally so a response is visible the cycle after push.
module dmem_rsp_fifo
    import dmem_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = rsp_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    entry_t             store [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_ptr_reg];

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers and occupancy, wrapping at DEPTH (need not be a power of 2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/data_memory_pipe.sv
// data_memory_pipe: byte-addressed, word-organised data RAM with a
// valid/ready request channel, RD_LAT-cycle reads, byte write strobes and a
// buffered, back-pressurable response channel.
// Optional macro DMEM_STATS_EN adds saturating read/write/error counters.
module data_memory_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 64,
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    data_memory_pipe_if.slave  bus
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]        stat_rd,
    output logic [31:0]        stat_wr,
    output logic [31:0]        stat_err
`endif
);

    localparam int NB     = DATA_W / 8;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int HI_LSB = IDX_W + BYTE_OFF_W;
    localparam int NSTG   = (RD_LAT > 1) ? RD_LAT - 1 : 1;
    localparam int OUT_W  = $clog2(RSP_DEPTH + 1);

    `DMEM_PARAM_CHECK(g_chk_lat,   rd_lat_ok(RD_LAT),                "RD_LAT must be in 1..4")
    `DMEM_PARAM_CHECK(g_chk_rsp,   rsp_depth_ok(RSP_DEPTH, RD_LAT),  "RSP_DEPTH must be >= RD_LAT")
    `DMEM_PARAM_CHECK(g_chk_depth, is_pow2(DEPTH) && (DEPTH >= 2),   "DEPTH must be a power of 2, >= 2")
    `DMEM_PARAM_CHECK(g_chk_dw,    (DATA_W % 8 == 0) && (DATA_W > 0), "DATA_W must be a multiple of 8")
    `DMEM_PARAM_CHECK(g_chk_aw,    ADDR_W > HI_LSB,                  "ADDR_W too small for DEPTH")

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_w_t;

    // ---------------- request decode ----------------
    logic [IDX_W-1:0] idx;
    logic             misaligned;
    logic             out_of_range;
    logic             acc_err;
    logic             accept;
    logic             rd_fire;
    logic             wr_fire;
    logic [NB-1:0]    byte_we;

    logic [OUT_W-1:0] outstanding_reg;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    // req_ready only looks at registered state; the FIFO-full term is
    // implied by the count but keeps the two views tied together.
    assign bus.req_ready = (outstanding_reg < OUT_W'(RSP_DEPTH)) && !fifo_full;

    assign idx          = bus.req_addr[HI_LSB-1:BYTE_OFF_W];
    assign misaligned   = |bus.req_addr[BYTE_OFF_W-1:0];
    assign out_of_range = |bus.req_addr[ADDR_W-1:HI_LSB];
    assign acc_err      = misaligned || out_of_range;
    assign accept       = bus.req_valid && bus.req_ready;
    assign rd_fire      = accept && !bus.req_we;
    assign wr_fire      = accept && bus.req_we;

    for (genvar gi = 0; gi < NB; gi++) begin : g_be
        assign byte_we[gi] = wr_fire && !acc_err && bus.req_be[gi];
    end

    // ---------------- storage ----------------
    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane writes; erroneous writes are suppressed via byte_we.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (byte_we[b]) begin
                mem[idx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read pipeline ----------------
    logic   push;
    rsp_w_t push_data;

    if (RD_LAT == 1) begin : g_lat1
        // Single-cycle read: the FIFO entry itself is the read register.
        always_comb begin
            push           = rd_fire;
            push_data.err  = acc_err;
            push_data.data = acc_err ? '0 : mem[idx];
        end
    end else begin : g_pipe
        logic [NSTG-1:0]   stg_valid_reg;
        logic [NSTG-1:0]   stg_err_reg;
        logic [DATA_W-1:0] stg_data_reg [NSTG];

        // Stage 0 is the RAM output register; later stages just shift.
        always_ff @(posedge clk) begin
            if (rd_fire) begin
                stg_data_reg[0] <= acc_err ? '0 : mem[idx];
            end
            for (int s = 1; s < NSTG; s++) begin
                stg_data_reg[s] <= stg_data_reg[s-1];
            end
        end

        // Valid/error tags travel with the data; cleared on reset so
        // in-flight reads vanish.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stg_valid_reg <= '0;
                stg_err_reg   <= '0;
            end else begin
                stg_valid_reg[0] <= rd_fire;
                stg_err_reg[0]   <= rd_fire && acc_err;
                for (int s = 1; s < NSTG; s++) begin
                    stg_valid_reg[s] <= stg_valid_reg[s-1];
                    stg_err_reg[s]   <= stg_err_reg[s-1];
                end
            end
        end

        always_comb begin
            push           = stg_valid_reg[NSTG-1];
            push_data.err  = stg_err_reg[NSTG-1];
            push_data.data = stg_data_reg[NSTG-1];
        end
    end

    // ---------------- response FIFO ----------------
    rsp_w_t head;

    dmem_rsp_fifo #(
        .DEPTH   (RSP_DEPTH),
        .entry_t (rsp_w_t)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    logic [DATA_W-1:0] last_data_reg;
    logic              last_err_reg;
    logic              err_sticky_reg;

    assign pop           = !fifo_empty && bus.rsp_ready;
    assign bus.rsp_valid = !fifo_empty;
    assign bus.rsp_rdata = fifo_empty ? last_data_reg : head.data;
    assign bus.rsp_err   = fifo_empty ? last_err_reg  : head.err;
    assign bus.err_sticky = err_sticky_reg;

    // Remember the last delivered response so outputs hold while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_data_reg <= '0;
            last_err_reg  <= 1'b0;
        end else if (pop) begin
            last_data_reg <= head.data;
            last_err_reg  <= head.err;
        end
    end

    // Outstanding reads: pipeline plus FIFO occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_reg <= '0;
        end else begin
            case ({rd_fire, pop})
                2'b10:   outstanding_reg <= outstanding_reg + OUT_W'(1);
                2'b01:   outstanding_reg <= outstanding_reg - OUT_W'(1);
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end

    // Sticky flag for any rejected write since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky_reg <= 1'b0;
        end else if (wr_fire && acc_err) begin
            err_sticky_reg <= 1'b1;
        end
    end

`ifdef DMEM_STATS_EN
    logic [31:0] stat_rd_reg;
    logic [31:0] stat_wr_reg;
    logic [31:0] stat_err_reg;

    assign stat_rd  = stat_rd_reg;
    assign stat_wr  = stat_wr_reg;
    assign stat_err = stat_err_reg;

    // Saturating access counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_reg  <= '0;
            stat_wr_reg  <= '0;
            stat_err_reg <= '0;
        end else begin
            if (rd_fire && (stat_rd_reg != '1)) begin
                stat_rd_reg <= stat_rd_reg + 32'd1;
            end
            if (wr_fire && (stat_wr_reg != '1)) begin
                stat_wr_reg <= stat_wr_reg + 32'd1;
            end
            if (accept && acc_err && (stat_err_reg != '1)) begin
                stat_err_reg <= stat_err_reg + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed bench for data_memory_pipe (default parameters, RD_LAT=2,
// RSP_DEPTH=4, DEPTH=64). Inputs change and outputs are sampled on the
// falling clock edge.
module tb_data_memory_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    data_memory_pipe_if #(.DATA_W(32), .ADDR_W(32)) bus_if ();

`ifdef DMEM_STATS_EN
    logic [31:0] stat_rd;
    logic [31:0] stat_wr;
    logic [31:0] stat_err;
`endif

    data_memory_pipe #(
        .DATA_W    (32),
        .ADDR_W    (32),
        .DEPTH     (64),
        .RD_LAT    (2),
        .RSP_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
`ifdef DMEM_STATS_EN
        ,
        .stat_rd  (stat_rd),
        .stat_wr  (stat_wr),
        .stat_err (stat_err)
`endif
    );

    int err_cnt = 0;
    int chk_cnt = 0;
    int n_acc;
    logic acc_now;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end else begin
            $display("  ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Write one word; starts and ends just after a falling edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b1;
        bus_if.req_addr  = a;
        bus_if.req_wdata = d;
        bus_if.req_be    = b;
        check("wr_ready", bus_if.req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        $display("WR addr=0x%0h data=0x%0h be=0x%0h", a, d, b);
    endtask

    // Single read with rsp_ready=1: response must appear exactly two
    // cycles after the accepting edge and be consumed the cycle after.
    task automatic read_expect(input string tag, input logic [31:0] a,
                               input logic [31:0] exp_d, input logic exp_e);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = a;
        check({tag, "_ready"}, bus_if.req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        check({tag, "_early"}, bus_if.rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, bus_if.rsp_valid, 1);
        check({tag, "_rdata"}, bus_if.rsp_rdata, exp_d);
        check({tag, "_err"},   bus_if.rsp_err,   exp_e);
        $display("RD addr=0x%0h data=0x%0h err=%0d", a, bus_if.rsp_rdata, bus_if.rsp_err);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_drained"}, bus_if.rsp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        bus_if.req_be    = '0;
        bus_if.rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid",  bus_if.rsp_valid,  0);
        check("rst_rdata",  bus_if.rsp_rdata,  0);
        check("rst_err",    bus_if.rsp_err,    0);
        check("rst_sticky", bus_if.err_sticky, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", bus_if.req_ready, 1);

        // Basic write then read
        do_write(32'h4, 32'h0000000A, 4'hF);
        read_expect("t1", 32'h4, 32'h0000000A, 1'b0);

        // Byte strobes: bytes 0 and 2 replaced
        do_write(32'h8, 32'h11223344, 4'hF);
        do_write(32'h8, 32'hAABBCCDD, 4'b0101);
        read_expect("t2", 32'h8, 32'h11BB33DD, 1'b0);

        // Error handling
        read_expect("t3_mis", 32'h6, 32'h0, 1'b1);
        check("t3_sticky_rd", bus_if.err_sticky, 0);
        do_write(32'h0, 32'h5555AAAA, 4'hF);
        check("t3_sticky_ok", bus_if.err_sticky, 0);
        do_write(32'h400, 32'hDEADBEEF, 4'hF);
        check("t3_sticky_oor", bus_if.err_sticky, 1);
        do_write(32'h9, 32'hFFFFFFFF, 4'hF);
        read_expect("t3_m0", 32'h0, 32'h5555AAAA, 1'b0);
        read_expect("t3_m8", 32'h8, 32'h11BB33DD, 1'b0);

        // Fill words 0x40..0x7C
        for (int k = 0; k < 16; k++) begin
            do_write(32'h40 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 4'hF);
        end

        // Back-pressure: only RSP_DEPTH reads accepted
        bus_if.rsp_ready = 1'b0;
        n_acc = 0;
        exp_q.delete();
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = 32'h40;
        for (int c = 0; c < 8; c++) begin
            acc_now = bus_if.req_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc_now) begin
                exp_q.push_back(32'hC0DE0000 + 32'(n_acc));
                n_acc++;
                bus_if.req_addr = 32'h40 + 32'(4 * n_acc);
            end
        end
        bus_if.req_valid = 1'b0;
        check("t4_accepts",  n_acc, 4);
        check("t4_rdy_low",  bus_if.req_ready, 0);
        check("t4_valid",    bus_if.rsp_valid, 1);
        check("t4_hold",     bus_if.rsp_rdata, 32'hC0DE0000);
        @(negedge clk);
        check("t4_hold2",    bus_if.rsp_rdata, 32'hC0DE0000);
        bus_if.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t4_dvalid", bus_if.rsp_valid, 1);
            check("t4_data",   bus_if.rsp_rdata, exp_q[k]);
            $display("RD drain idx=%0d data=0x%0h", k, bus_if.rsp_rdata);
            @(posedge clk);
            @(negedge clk);
            if (k == 0) check("t4_rdy_back", bus_if.req_ready, 1);
        end
        check("t4_empty", bus_if.rsp_valid, 0);

        // Streaming reads at full rate
        for (int c = 0; c < 18; c++) begin
            if (c < 16) begin
                bus_if.req_valid = 1'b1;
                bus_if.req_we    = 1'b0;
                bus_if.req_addr  = 32'h40 + 32'(4 * c);
                check("t5_ready", bus_if.req_ready, 1);
            end else begin
                bus_if.req_valid = 1'b0;
            end
            if (c >= 2) begin
                check("t5_valid", bus_if.rsp_valid, 1);
                check("t5_data",  bus_if.rsp_rdata, 32'hC0DE0000 + 32'(c - 2));
                $display("RD stream idx=%0d data=0x%0h", c - 2, bus_if.rsp_rdata);
            end else begin
                check("t5_lat", bus_if.rsp_valid, 0);
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("t5_empty", bus_if.rsp_valid, 0);

        // Reset with three reads in flight
        bus_if.rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus_if.req_valid = 1'b1;
            bus_if.req_we    = 1'b0;
            bus_if.req_addr  = 32'h40 + 32'(4 * c);
            @(posedge clk);
            @(negedge clk);
        end
        bus_if.req_valid = 1'b0;
        check("t6_pre_valid", bus_if.rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", bus_if.rsp_valid, 0);
        check("t6_rst_ready", bus_if.req_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_if.rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("t6_no_stale", bus_if.rsp_valid, 0);
            @(negedge clk);
        end
        read_expect("t6_m8", 32'h8, 32'h11BB33DD, 1'b0);
        read_expect("t6_m4", 32'h4, 32'h0000000A, 1'b0);
        check("t6_sticky", bus_if.err_sticky, 0);
`ifdef DMEM_STATS_EN
        check("stat_rd",  stat_rd,  2);
        check("stat_wr",  stat_wr,  0);
        check("stat_err", stat_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
